// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the PIO event-capture block: register addresses,
// edge-mode encodings and bit positions inside ctrl and fifo_status.
package soc_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA        = 3'd0;
  localparam logic [2:0] ADDR_CTRL        = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK    = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP    = 3'd3;
  localparam logic [2:0] ADDR_FIFO_DATA   = 3'd4;
  localparam logic [2:0] ADDR_FIFO_STATUS = 3'd5;

  typedef enum logic [1:0] {
    MODE_RISE  = 2'b00,
    MODE_FALL  = 2'b01,
    MODE_ANY   = 2'b10,
    MODE_LEVEL = 2'b11
  } edge_mode_e;

  localparam int CTRL_FIFO_EN_BIT     = 2;
  localparam int CTRL_FIFO_IRQ_EN_BIT = 3;

  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 31;

endpackage

// File: rtl/soc_system_pio_sync_fifo.sv
// Single-clock snapshot FIFO with power-of-two depth; pointers wrap naturally
// and the count carries one extra bit so full and empty are distinguishable.
module soc_system_pio_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE    = 1;
  localparam logic [CW-1:0] CNT_ONE    = 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Handshake: a push is taken when i_push is high and there is room (or a pop
  // frees a slot in the same cycle); a pop is taken when i_pop is high and the
  // FIFO is non-empty. Requests that are not taken have no effect.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/soc_system_pio_event_capture.sv
// Avalon-MM PIO input port with synchronised edge/level event capture,
// W1C edge register, level interrupt and a snapshot FIFO of masked events.
module soc_system_pio_event_capture
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [3:0]       r_ctrl;
  logic [2:0]       r_settle;
  logic             r_ovf;
  logic [31:0]      r_readdata;

  logic             w_rd;
  logic             w_wr;
  logic [WIDTH-1:0] w_sync_out;
  logic [WIDTH-1:0] w_detect;
  logic [WIDTH-1:0] w_clr;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_ovf_clr;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [WIDTH-1:0] w_fifo_rdata;
  logic [31:0]      w_rd_mux;
  edge_mode_e       w_mode;

  assign w_rd       = chipselect & ~read_n;
  assign w_wr       = chipselect & ~write_n;
  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_mode     = edge_mode_e'(r_ctrl[1:0]);

  // Detection stays off until the chain and prev have both refilled after reset,
  // so inputs already high at reset release never look like a rising edge.
  always_comb begin
    w_detect = '0;
    if (r_settle == SETTLE) begin
      case (w_mode)
        MODE_RISE:  w_detect = w_sync_out & ~r_prev;
        MODE_FALL:  w_detect = ~w_sync_out & r_prev;
        MODE_ANY:   w_detect = w_sync_out ^ r_prev;
        MODE_LEVEL: w_detect = w_sync_out;
        default:    w_detect = '0;
      endcase
    end
  end

  assign w_clr     = (w_wr && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;
  assign w_push    = r_ctrl[CTRL_FIFO_EN_BIT] & (|(w_detect & r_irq_mask));
  assign w_pop     = w_rd && (address == ADDR_FIFO_DATA) && !w_empty;
  assign w_drop    = w_push & w_full & ~w_pop;
  assign w_ovf_clr = w_wr && (address == ADDR_FIFO_STATUS) && writedata[STAT_OVF_BIT];

  soc_system_pio_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_wdata (w_sync_out),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:        w_rd_mux[WIDTH-1:0] = w_sync_out;
      ADDR_CTRL:        w_rd_mux[3:0]       = r_ctrl;
      ADDR_IRQ_MASK:    w_rd_mux[WIDTH-1:0] = r_irq_mask;
      ADDR_EDGE_CAP:    w_rd_mux[WIDTH-1:0] = r_edge_cap;
      ADDR_FIFO_DATA:   if (!w_empty) w_rd_mux[WIDTH-1:0] = w_fifo_rdata;
      ADDR_FIFO_STATUS: begin
        w_rd_mux[CW-1:0]           = w_count;
        w_rd_mux[STAT_EMPTY_BIT]   = w_empty;
        w_rd_mux[STAT_FULL_BIT]    = w_full;
        w_rd_mux[STAT_OVF_BIT]     = r_ovf;
      end
      default:          w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev     <= '0;
      r_irq_mask <= '0;
      r_edge_cap <= '0;
      r_ctrl     <= '0;
      r_settle   <= '0;
      r_ovf      <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync_out;
      if (r_settle != SETTLE) r_settle <= r_settle + 3'd1;
      // A detect in the same cycle as a W1C clear keeps the bit set.
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_detect;
      if (w_wr && address == ADDR_CTRL)     r_ctrl     <= writedata[3:0];
      if (w_wr && address == ADDR_IRQ_MASK) r_irq_mask <= writedata[WIDTH-1:0];
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      r_readdata <= w_rd ? w_rd_mux : '0;
    end
  end

  assign readdata = r_readdata;
  assign irq      = (|(r_edge_cap & r_irq_mask)) | (r_ctrl[CTRL_FIFO_IRQ_EN_BIT] & ~w_empty);

endmodule

// File: tb/tb_soc_system_pio_event_capture.sv
// Directed bench for the PIO event-capture block with a 4-entry snapshot FIFO.
module tb_soc_system_pio_event_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] in_port = 32'hFFFF_FFFF;
  logic        irq;

  int n_total = 0;
  int n_bad   = 0;

  soc_system_pio_event_capture #(
    .WIDTH       (32),
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic set_in(input logic [31:0] v);
    @(negedge clk);
    in_port = v;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1;
    n_total++;
    if (readdata !== 32'h0) begin n_bad++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'h0); end
    n_total++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(6);
    bus_read(3'd0, d);
    n_total++;
    if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_data got=%h exp=%h", d, 32'hFFFF_FFFF); end
    bus_read(3'd3, d);
    n_total++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL reset_held_high_edge got=%h exp=%h", d, 32'h0); end
    bus_read(3'd5, d);
    n_total++;
    if (d !== 32'h0001_0000) begin n_bad++; $display("FAIL reset_status got=%h exp=%h", d, 32'h0001_0000); end
    n_total++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_release_irq got=%b exp=0", irq); end
    set_in(32'h0);
    wait_cycles(4);
  endtask

  task automatic test_regs();
    logic [31:0] d;
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_read(3'd1, d);
    n_total++;
    if (d !== 32'h0000_000F) begin n_bad++; $display("FAIL ctrl_readback got=%h exp=%h", d, 32'hF); end
    bus_write(3'd1, 32'h0);
    bus_write(3'd2, 32'hA5A5_A5A5);
    bus_read(3'd2, d);
    n_total++;
    if (d !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL mask_readback got=%h exp=%h", d, 32'hA5A5_A5A5); end
    @(negedge clk);
    n_total++;
    if (readdata !== 32'h0) begin n_bad++; $display("FAIL readdata_idle got=%h exp=%h", readdata, 32'h0); end
    bus_write(3'd2, 32'h0);
    bus_write(3'd6, 32'h1234_5678);
    bus_read(3'd6, d);
    n_total++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL addr6 got=%h exp=%h", d, 32'h0); end
    bus_read(3'd7, d);
    n_total++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL addr7 got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_rise_irq();
    logic [31:0] d;
    bus_write(3'd1, 32'h0);
    bus_write(3'd2, 32'h1);
    @(negedge clk);
    in_port = 32'h1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_total++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL rise_irq_early got=%b exp=0", irq); end
    @(posedge clk);
    #1;
    n_total++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL rise_irq_on_time got=%b exp=1", irq); end
    bus_read(3'd3, d);
    n_total++;
    if (d !== 32'h1) begin n_bad++; $display("FAIL rise_edge_cap got=%h exp=%h", d, 32'h1); end
    bus_write(3'd3, 32'h1);
    n_total++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL rise_irq_cleared got=%b exp=0", irq); end
  endtask

  task automatic test_fall();
    logic [31:0] d;
    bus_write(3'd1, 32'h1);
    set_in(32'hF);
    wait_cycles(4);
    bus_write(3'd3, 32'hFFFF_FFFF);
    set_in(32'h0);
    wait_cycles(4);
    bus_read(3'd3, d);
    n_total++;
    if (d !== 32'hF) begin n_bad++; $display("FAIL fall_edge_cap got=%h exp=%h", d, 32'hF); end
    bus_write(3'd3, 32'hF);
  endtask

  task automatic test_any_edge();
    logic [31:0] d;
    bus_write(3'd1, 32'h2);
    set_in(32'h10);
    wait_cycles(4);
    bus_read(3'd3, d);
    n_total++;
    if (d !== 32'h10) begin n_bad++; $display("FAIL any_first_edge got=%h exp=%h", d, 32'h10); end
    bus_write(3'd3, 32'h10);
    bus_read(3'd3, d);
    n_total++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL any_w1c got=%h exp=%h", d, 32'h0); end
    set_in(32'h0);
    wait_cycles(4);
    bus_read(3'd3, d);
    n_total++;
    if (d !== 32'h10) begin n_bad++; $display("FAIL any_second_edge got=%h exp=%h", d, 32'h10); end
    bus_write(3'd3, 32'h10);
  endtask

  task automatic test_level();
    logic [31:0] d;
    bus_write(3'd1, 32'h3);
    set_in(32'h100);
    wait_cycles(4);
    bus_read(3'd3, d);
    n_total++;
    if (d !== 32'h100) begin n_bad++; $display("FAIL level_set got=%h exp=%h", d, 32'h100); end
    bus_write(3'd3, 32'h100);
    bus_read(3'd3, d);
    n_total++;
    if (d !== 32'h100) begin n_bad++; $display("FAIL level_reassert got=%h exp=%h", d, 32'h100); end
    set_in(32'h0);
    wait_cycles(4);
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_read(3'd3, d);
    n_total++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL level_low_clear got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    bus_write(3'd1, 32'h0);
    @(negedge clk);
    in_port = 32'h4;
    @(negedge clk);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd3; writedata = 32'h4;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    bus_read(3'd3, d);
    n_total++;
    if (d !== 32'h4) begin n_bad++; $display("FAIL w1c_set_wins got=%h exp=%h", d, 32'h4); end
    bus_write(3'd3, 32'hFFFF_FFFF);
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] d;
    logic [31:0] pat [5];
    pat[0] = 32'h01; pat[1] = 32'h03; pat[2] = 32'h07; pat[3] = 32'h0F; pat[4] = 32'h1F;
    set_in(32'h0);
    wait_cycles(4);
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_write(3'd2, 32'hFF);
    bus_write(3'd1, 32'h4);
    for (int i = 0; i < 5; i++) begin
      set_in(pat[i]);
      wait_cycles(4);
    end
    bus_read(3'd5, d);
    n_total++;
    if (d !== 32'h8002_0004) begin n_bad++; $display("FAIL ovf_status got=%h exp=%h", d, 32'h8002_0004); end
    n_total++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL ovf_irq got=%b exp=1", irq); end
    bus_write(3'd1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus_read(3'd4, d);
      n_total++;
      if (d !== pat[i]) begin n_bad++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, d, pat[i]); end
    end
    bus_read(3'd4, d);
    n_total++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL ovf_pop_empty got=%h exp=%h", d, 32'h0); end
    bus_read(3'd5, d);
    n_total++;
    if (d !== 32'h8001_0000) begin n_bad++; $display("FAIL ovf_sticky got=%h exp=%h", d, 32'h8001_0000); end
    bus_write(3'd5, 32'h8000_0000);
    bus_read(3'd5, d);
    n_total++;
    if (d !== 32'h0001_0000) begin n_bad++; $display("FAIL ovf_w1c got=%h exp=%h", d, 32'h0001_0000); end
  endtask

  task automatic test_fifo_irq();
    logic [31:0] d;
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_write(3'd2, 32'h1);
    bus_write(3'd1, 32'hC);
    set_in(32'h0);
    wait_cycles(4);
    set_in(32'h1);
    wait_cycles(4);
    bus_write(3'd3, 32'hFFFF_FFFF);
    n_total++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL fifo_irq_pending got=%b exp=1", irq); end
    bus_read(3'd4, d);
    n_total++;
    if (d !== 32'h1) begin n_bad++; $display("FAIL fifo_irq_pop got=%h exp=%h", d, 32'h1); end
    n_total++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL fifo_irq_drained got=%b exp=0", irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(3'd2, 32'hFF);
    bus_write(3'd1, 32'h4);
    set_in(32'h0);
    wait_cycles(4);
    set_in(32'h1); wait_cycles(4);
    set_in(32'h3); wait_cycles(4);
    set_in(32'h7); wait_cycles(4);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = 3'd5;
    @(negedge clk);
    n_total++;
    if (readdata !== 32'h3) begin n_bad++; $display("FAIL mid_count3 got=%h exp=%h", readdata, 32'h3); end
    chipselect = 1'b0; read_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    n_total++;
    if (readdata !== 32'h0) begin n_bad++; $display("FAIL mid_reset_readdata got=%h exp=%h", readdata, 32'h0); end
    n_total++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL mid_reset_irq got=%b exp=0", irq); end
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(6);
    bus_read(3'd5, d);
    n_total++;
    if (d !== 32'h0001_0000) begin n_bad++; $display("FAIL mid_reset_status got=%h exp=%h", d, 32'h0001_0000); end
    bus_read(3'd3, d);
    n_total++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL mid_reset_edge got=%h exp=%h", d, 32'h0); end
    bus_read(3'd1, d);
    n_total++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL mid_reset_ctrl got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] pat [4];
    pat[0] = 32'h0F; pat[1] = 32'h1F; pat[2] = 32'h3F; pat[3] = 32'h7F;
    bus_write(3'd2, 32'hFF);
    bus_write(3'd1, 32'h4);
    for (int i = 0; i < 4; i++) begin
      set_in(pat[i]);
      wait_cycles(4);
    end
    @(negedge clk);
    in_port = 32'hFF;
    @(negedge clk);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = 3'd4;
    @(negedge clk);
    n_total++;
    if (readdata !== 32'h0F) begin n_bad++; $display("FAIL b2b_pop_head got=%h exp=%h", readdata, 32'h0F); end
    chipselect = 1'b0; read_n = 1'b1;
    bus_read(3'd5, d);
    n_total++;
    if (d !== 32'h0002_0004) begin n_bad++; $display("FAIL b2b_status got=%h exp=%h", d, 32'h0002_0004); end
    bus_read(3'd4, d);
    n_total++;
    if (d !== 32'h1F) begin n_bad++; $display("FAIL b2b_pop1 got=%h exp=%h", d, 32'h1F); end
    bus_read(3'd4, d);
    n_total++;
    if (d !== 32'h3F) begin n_bad++; $display("FAIL b2b_pop2 got=%h exp=%h", d, 32'h3F); end
    bus_read(3'd4, d);
    n_total++;
    if (d !== 32'h7F) begin n_bad++; $display("FAIL b2b_pop3 got=%h exp=%h", d, 32'h7F); end
    bus_read(3'd4, d);
    n_total++;
    if (d !== 32'hFF) begin n_bad++; $display("FAIL b2b_pop4 got=%h exp=%h", d, 32'hFF); end
    bus_read(3'd5, d);
    n_total++;
    if (d !== 32'h0001_0000) begin n_bad++; $display("FAIL b2b_empty got=%h exp=%h", d, 32'h0001_0000); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_rise_irq();
    test_fall();
    test_any_edge();
    test_level();
    test_w1c_collision();
    test_fifo_overflow();
    test_fifo_irq();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
